// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for loads/stores
//   - FSM state enum
//   - access size enum and funct3 -> {size, sign} decode
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  typedef struct packed {
    lsu_size_e size;
    logic      sign;
  } lsu_dec_t;

  // Unlisted funct3 values fall back to a word access.
  function automatic lsu_dec_t decode_f3(input logic [2:0] f3);
    lsu_dec_t d;
    d.size = SZ_W;
    d.sign = 1'b0;
    case (f3)
      F3_B:  begin d.size = SZ_B; d.sign = 1'b1; end
      F3_H:  begin d.size = SZ_H; d.sign = 1'b1; end
      F3_BU: begin d.size = SZ_B; d.sign = 1'b0; end
      F3_HU: begin d.size = SZ_H; d.sign = 1'b0; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   st_size/st_off/st_data -> st_be, st_wdata : store enables and replicated data
//   ld_size/ld_sign/ld_off/ld_rdata -> ld_data : extracted, extended load value
import lsu_pkg::*;

module lsu_lane_align (
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  lsu_size_e   ld_size,
  input  logic        ld_sign,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns the MEM instruction into a req/ack
// data-memory transaction and returns the extended load result to MEM_WB.
//   mem_*        : MEM-stage instruction, address and store data
//   dram_*       : registered request interface, dram_ack/dram_rdata return
//   DRAM_rd      : registered load result
//   stall_req    : holds upstream stages while an access is pending
//   misalign     : combinational flag, misaligned access is dropped
//   bus_err      : 1-cycle pulse when the access times out
import lsu_pkg::*;

module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 256,
  parameter bit          TO_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        mem_ld,
  input  logic        mem_st,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rD2,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [3:0]  dram_be,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata,
  output logic [31:0] DRAM_rd,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e  state, state_n;
  logic [CW-1:0] cnt;
  lsu_dec_t    dec;
  lsu_size_e   lat_size;
  logic        lat_sign;
  logic [1:0]  lat_off;
  logic        acc, mis, timeout;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, ld_ext;
  logic        unused_inst;

  assign unused_inst = ^{mem_inst[31:15], mem_inst[11:0]};

  assign dec = decode_f3(mem_inst[14:12]);
  assign acc = mem_valid & (mem_ld | mem_st);
  assign mis = ((dec.size == SZ_H) & mem_alu_result[0]) |
               ((dec.size == SZ_W) & (mem_alu_result[1:0] != 2'b00));
  assign timeout = TO_EN && (state == BUSY) && !dram_ack && (cnt == CNT_LAST);

  lsu_lane_align u_align (
    .st_size  (dec.size),
    .st_off   (mem_alu_result[1:0]),
    .st_data  (mem_rD2),
    .st_be    (be_n),
    .st_wdata (wdata_n),
    .ld_size  (lat_size),
    .ld_sign  (lat_sign),
    .ld_off   (lat_off),
    .ld_rdata (dram_rdata),
    .ld_data  (ld_ext)
  );

  always_comb begin
    state_n   = state;
    stall_req = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (mis) begin
            misalign = 1'b1;
          end else begin
            stall_req = 1'b1;
            state_n   = BUSY;
          end
        end
      end
      BUSY: begin
        stall_req = 1'b1;
        if (dram_ack || timeout) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      dram_req   <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_be    <= '0;
      dram_wdata <= '0;
      DRAM_rd    <= '0;
      bus_err    <= 1'b0;
      lat_size   <= SZ_W;
      lat_sign   <= 1'b0;
      lat_off    <= '0;
    end else begin
      state   <= state_n;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (state_n == BUSY) begin
            dram_req   <= 1'b1;
            dram_we    <= mem_st;
            dram_addr  <= {mem_alu_result[31:2], 2'b00};
            dram_be    <= be_n;
            dram_wdata <= wdata_n;
            lat_size   <= dec.size;
            lat_sign   <= dec.sign;
            lat_off    <= mem_alu_result[1:0];
            cnt        <= '0;
          end
        end
        BUSY: begin
          if (dram_ack) begin
            dram_req <= 1'b0;
            if (!dram_we) DRAM_rd <= ld_ext;
          end else if (timeout) begin
            dram_req <= 1'b0;
            DRAM_rd  <= '0;
            bus_err  <= 1'b1;
          end else if (cnt != CNT_LAST) begin
            // saturate rather than wrap when the timeout is disabled
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ld, mem_st;
  logic [31:0] mem_inst, mem_alu_result, mem_rD2;
  logic        dram_req, dram_we, dram_ack;
  logic [31:0] dram_addr, dram_wdata, dram_rdata, DRAM_rd;
  logic [3:0]  dram_be;
  logic        stall_req, misalign, bus_err;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned sc;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT(8), .TO_EN(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_valid      (mem_valid),
    .mem_inst       (mem_inst),
    .mem_ld         (mem_ld),
    .mem_st         (mem_st),
    .mem_alu_result (mem_alu_result),
    .mem_rD2        (mem_rD2),
    .dram_req       (dram_req),
    .dram_we        (dram_we),
    .dram_addr      (dram_addr),
    .dram_be        (dram_be),
    .dram_wdata     (dram_wdata),
    .dram_ack       (dram_ack),
    .dram_rdata     (dram_rdata),
    .DRAM_rd        (DRAM_rd),
    .stall_req      (stall_req),
    .misalign       (misalign),
    .bus_err        (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs are then driven 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_valid      = 1'b1;
    mem_ld         = ld;
    mem_st         = st;
    mem_inst       = {17'b0, f3, 12'b0};
    mem_alu_result = addr;
    mem_rD2        = data;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_ld = 1'b0; mem_st = 1'b0;
    mem_inst = '0; mem_alu_result = '0; mem_rD2 = '0;
    dram_ack = 1'b0; dram_rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_req",   {31'b0, dram_req},  32'h0);
    chk("rst_we",    {31'b0, dram_we},   32'h0);
    chk("rst_be",    {28'b0, dram_be},   32'h0);
    chk("rst_addr",  dram_addr,          32'h0);
    chk("rst_wdata", dram_wdata,         32'h0);
    chk("rst_rd",    DRAM_rd,            32'h0);
    chk("rst_berr",  {31'b0, bus_err},   32'h0);

    // 1: LB 0x103, ack in first BUSY cycle
    sc = 0;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    dram_rdata = 32'h80FF_1234;
    #1;
    chk("t1_idle_stall", {31'b0, stall_req}, 32'h1);
    chk("t1_idle_req",   {31'b0, dram_req},  32'h0);
    sc += stall_req;
    step();
    chk("t1_req",  {31'b0, dram_req}, 32'h1);
    chk("t1_addr", dram_addr,         32'h0000_0100);
    chk("t1_be",   {28'b0, dram_be},  32'h8);
    chk("t1_we",   {31'b0, dram_we},  32'h0);
    sc += stall_req;
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    #1;
    chk("t1_rd",       DRAM_rd,           32'hFFFF_FF80);
    chk("t1_done_req", {31'b0, dram_req}, 32'h0);
    sc += stall_req;
    step();
    mem_valid = 1'b0;
    #1;
    sc += stall_req;
    chk("t1_stall_cycles", sc, 32'd2);

    // 2: SH 0x202
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
    step();
    chk("t2_req",   {31'b0, dram_req}, 32'h1);
    chk("t2_we",    {31'b0, dram_we},  32'h1);
    chk("t2_be",    {28'b0, dram_be},  32'hC);
    chk("t2_wdata", dram_wdata,        32'hABCD_ABCD);
    chk("t2_addr",  dram_addr,         32'h0000_0200);
    dram_rdata = 32'h1234_5678;
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    #1;
    chk("t2_rd_keep", DRAM_rd, 32'hFFFF_FF80);
    step();
    mem_valid = 1'b0;

    // SB lane check: offset 1
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5);
    step();
    chk("sb_be",    {28'b0, dram_be}, 32'h2);
    chk("sb_wdata", dram_wdata,       32'hA5A5_A5A5);
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    step();
    mem_valid = 1'b0;

    // 3: LW 0x101 misaligned; a stray ack in IDLE must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
    dram_ack = 1'b1; dram_rdata = 32'h5555_5555;
    #1;
    chk("t3_mis",   {31'b0, misalign},  32'h1);
    chk("t3_stall", {31'b0, stall_req}, 32'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("t3_req", {31'b0, dram_req}, 32'h0);
    end
    chk("t3_rd_keep", DRAM_rd, 32'hFFFF_FF80);
    dram_ack = 1'b0;
    // misaligned half
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0);
    #1;
    chk("lh_mis", {31'b0, misalign}, 32'h1);
    mem_valid = 1'b0;
    #1;
    chk("nomem_mis", {31'b0, misalign}, 32'h0);

    // 4: LHU 0x4, ack after 5 BUSY cycles
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0004, 32'h0);
    dram_rdata = 32'h0000_9ABC;
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("t4_req",   {31'b0, dram_req},  32'h1);
      chk("t4_addr",  dram_addr,          32'h0000_0004);
      chk("t4_be",    {28'b0, dram_be},   32'h3);
      chk("t4_stall", {31'b0, stall_req}, 32'h1);
      step();
    end
    chk("t4_req6", {31'b0, dram_req}, 32'h1);
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    #1;
    chk("t4_rd", DRAM_rd, 32'h0000_9ABC);
    step();
    mem_valid = 1'b0;

    // 5: timeout after 8 BUSY cycles
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    step();
    for (int unsigned i = 0; i < 8; i++) begin
      chk("t5_req_busy",  {31'b0, dram_req}, 32'h1);
      chk("t5_berr_busy", {31'b0, bus_err},  32'h0);
      step();
    end
    chk("t5_berr",  {31'b0, bus_err},   32'h1);
    chk("t5_req",   {31'b0, dram_req},  32'h0);
    chk("t5_rd",    DRAM_rd,            32'h0);
    chk("t5_stall", {31'b0, stall_req}, 32'h0);
    step();
    mem_valid = 1'b0;
    #1;
    chk("t5_berr_pulse", {31'b0, bus_err},   32'h0);
    chk("t5_idle_stall", {31'b0, stall_req}, 32'h0);

    // LH upper half, sign-extended: gives DRAM_rd a nonzero value before the reset test
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
    dram_rdata = 32'h8001_0000;
    step();
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    #1;
    chk("lh_rd", DRAM_rd, 32'hFFFF_8001);
    step();
    mem_valid = 1'b0;

    // 6: reset in the 2nd BUSY cycle, ack one cycle later
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
    step();
    step();
    chk("t6_req_busy", {31'b0, dram_req}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_valid = 1'b0;
    dram_ack = 1'b1; dram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_req",   {31'b0, dram_req},  32'h0);
    chk("t6_rd",    DRAM_rd,            32'h0);
    chk("t6_stall", {31'b0, stall_req}, 32'h0);
    step();
    dram_ack = 1'b0;
    #1;
    chk("t6_ack_ign_rd",  DRAM_rd,           32'h0);
    chk("t6_ack_ign_req", {31'b0, dram_req}, 32'h0);

    // fresh LBU after reset: byte 1 zero-extended
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0021, 32'h0);
    dram_rdata = 32'h0000_F100;
    step();
    chk("lbu_req",  {31'b0, dram_req}, 32'h1);
    chk("lbu_addr", dram_addr,         32'h0000_0020);
    chk("lbu_be",   {28'b0, dram_be},  32'h2);
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    #1;
    chk("lbu_rd", DRAM_rd, 32'h0000_00F1);
    step();
    mem_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
